// File: rtl/mole_round_ctrl.sv
// Whack-a-mole round sequencer: requests a random box, lights it, judges the
// player's press or timeout, keeps score and misses, and ends the game.
module mole_round_ctrl #(
  parameter int TIMEOUT_CYCLES = 50000000,
  parameter int GAP_CYCLES     = 12500000,
  parameter int MAX_MISSES     = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] rnd,
  input  logic [3:0] btn,
  output logic       rnd_req,
  output logic [3:0] mole_box,
  output logic [7:0] score,
  output logic [2:0] misses,
  output logic       hit_pulse,
  output logic       miss_pulse,
  output logic       game_over
);

  // One shared timer covers both the SHOW timeout and the GAP length.
  localparam int TMAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int TW   = $clog2(TMAX);

  typedef enum logic [2:0] {IDLE, REQ, LOAD, SHOW, GAP, OVER} state_t;

  state_t          state;
  logic [TW-1:0]   timer;
  logic [3:0]      btn_prev;
  logic [3:0]      press;
  logic            pressed;
  logic            on_mole;
  logic            timeout;
  logic            hit;
  logic            miss;
  logic [2:0]      misses_nxt;

  function automatic logic [3:0] box_map(input logic [2:0] r);
    case (r)
      3'b011, 3'b101: box_map = 4'b0010;
      3'b110:         box_map = 4'b0100;
      3'b111:         box_map = 4'b1000;
      default:        box_map = 4'b0001;
    endcase
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    sat_inc = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // A press in the timeout cycle wins; the timeout only counts with no press edge.
  assign press      = btn & ~btn_prev;
  assign pressed    = |press;
  assign on_mole    = |(press & mole_box);
  assign timeout    = (timer == TW'(TIMEOUT_CYCLES - 1));
  assign hit        = (state == SHOW) && pressed && on_mole;
  assign miss       = (state == SHOW) && (pressed ? !on_mole : timeout);
  assign misses_nxt = misses + 3'd1;
  assign hit_pulse  = hit;
  assign miss_pulse = miss;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      timer     <= '0;
      btn_prev  <= '0;
      mole_box  <= '0;
      score     <= '0;
      misses    <= '0;
      rnd_req   <= 1'b0;
      game_over <= 1'b0;
    end else begin
      btn_prev <= btn;
      rnd_req  <= 1'b0;
      case (state)
        IDLE, OVER: begin
          if (start) begin
            score     <= '0;
            misses    <= '0;
            game_over <= 1'b0;
            rnd_req   <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: state <= LOAD;
        LOAD: begin
          mole_box <= box_map(rnd);
          timer    <= '0;
          state    <= SHOW;
        end
        SHOW: begin
          if (hit) begin
            score    <= sat_inc(score);
            mole_box <= '0;
            timer    <= '0;
            state    <= GAP;
          end else if (miss) begin
            misses   <= misses_nxt;
            mole_box <= '0;
            timer    <= '0;
            if (misses_nxt == 3'(MAX_MISSES)) begin
              game_over <= 1'b1;
              state     <= OVER;
            end else begin
              state <= GAP;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        GAP: begin
          if (timer == TW'(GAP_CYCLES - 1)) begin
            rnd_req <= 1'b1;
            state   <= REQ;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Randomised round-level bench for mole_round_ctrl against an expectation model
// that predicts each round's outcome from the box map, press edges and counters.
module tb_mole_round_ctrl;

  localparam int TO = 8;
  localparam int G  = 4;
  localparam int MM = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [2:0] rnd = 3'd0;
  logic [3:0] btn = 4'd0;
  logic       rnd_req;
  logic [3:0] mole_box;
  logic [7:0] score;
  logic [2:0] misses;
  logic       hit_pulse;
  logic       miss_pulse;
  logic       game_over;

  int n_checks = 0;
  int n_fail   = 0;

  int         exp_score  = 0;
  int         exp_misses = 0;
  bit         exp_over   = 0;
  logic [3:0] prev_b     = 4'd0;

  mole_round_ctrl #(.TIMEOUT_CYCLES(TO), .GAP_CYCLES(G), .MAX_MISSES(MM)) dut (
    .clk(clk), .reset(reset), .start(start), .rnd(rnd), .btn(btn),
    .rnd_req(rnd_req), .mole_box(mole_box), .score(score), .misses(misses),
    .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .game_over(game_over)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] ref_box(input logic [2:0] r);
    if (r == 3'd7) return 4'b1000;
    if (r == 3'd6) return 4'b0100;
    if (r == 3'd3 || r == 3'd5) return 4'b0010;
    return 4'b0001;
  endfunction

  // Advance to the next cycle and apply its inputs; prev_b is what the design
  // should hold as the previous button sample for this new cycle.
  task automatic drive(input logic [3:0] b, input logic [2:0] r, input logic s, input logic rs);
    @(negedge clk);
    prev_b = reset ? 4'd0 : btn;
    btn = b; rnd = r; start = s; reset = rs;
    #1;
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_score"}, score, exp_score);
    chk({tag, "_misses"}, misses, exp_misses);
  endtask

  task automatic do_reset();
    drive(4'd0, 3'd0, 1'b0, 1'b1);
    drive(4'd0, 3'd0, 1'b0, 1'b0);
    exp_score = 0; exp_misses = 0; exp_over = 0;
    chk("rst_rnd_req", rnd_req, 0);
    chk("rst_mole_box", mole_box, 0);
    chk_counts("rst");
    chk("rst_hit", hit_pulse, 0);
    chk("rst_miss", miss_pulse, 0);
    chk("rst_over", game_over, 0);
  endtask

  // Current cycle must be IDLE or OVER; leaves the bench in the REQ cycle.
  task automatic start_game();
    drive(btn, 3'($urandom), 1'b1, 1'b0);
    drive(btn, 3'($urandom), 1'b0, 1'b0);
    exp_score = 0; exp_misses = 0; exp_over = 0;
    chk("start_rnd_req", rnd_req, 1);
    chk_counts("start");
    chk("start_over", game_over, 0);
    chk("start_box", mole_box, 0);
  endtask

  // Entered in a REQ cycle. Leaves the bench in the next REQ cycle, or the
  // first OVER cycle when the round ends the game.
  task automatic round(input logic [2:0] r, input int press_at, input logic [3:0] pv,
                       input logic [3:0] hold);
    logic [3:0] eb, cur, e;
    bit done, h, m;
    eb = ref_box(r);
    drive(hold, r, 1'b0, 1'b0);
    chk("load_rnd_req", rnd_req, 0);
    chk("load_box", mole_box, 0);
    done = 0;
    for (int j = 1; j <= TO && !done; j++) begin
      cur = (press_at > 0 && j >= press_at) ? pv : hold;
      drive(cur, 3'($urandom), 1'($urandom), 1'b0);
      e = btn & ~prev_b;
      h = (e & eb) != 0;
      m = !h && (e != 0 || j == TO);
      chk("show_box", mole_box, eb);
      chk("show_hit", hit_pulse, h);
      chk("show_miss", miss_pulse, m);
      chk("show_rnd_req", rnd_req, 0);
      if (h) begin
        if (exp_score < 255) exp_score++;
        done = 1;
      end else if (m) begin
        exp_misses++;
        if (exp_misses == MM) exp_over = 1;
        done = 1;
      end
    end
    if (exp_over) begin
      drive(btn, 3'($urandom), 1'b0, 1'b0);
      chk("over_flag", game_over, 1);
      chk("over_box", mole_box, 0);
      chk("over_rnd_req", rnd_req, 0);
      chk_counts("over");
    end else begin
      for (int g = 0; g < G; g++) begin
        drive(btn, 3'($urandom), 1'($urandom), 1'b0);
        chk("gap_box", mole_box, 0);
        chk("gap_rnd_req", rnd_req, 0);
        chk("gap_pulses", {hit_pulse, miss_pulse}, 0);
        chk("gap_over", game_over, 0);
        chk_counts("gap");
      end
      drive(btn, 3'($urandom), 1'b0, 1'b0);
      chk("next_rnd_req", rnd_req, 1);
    end
  endtask

  task automatic over_hold(input int n);
    for (int i = 0; i < n; i++) begin
      drive(4'($urandom), 3'($urandom), 1'b0, 1'b0);
      chk("hold_over", game_over, 1);
      chk("hold_box", mole_box, 0);
      chk("hold_rnd_req", rnd_req, 0);
      chk("hold_pulses", {hit_pulse, miss_pulse}, 0);
      chk_counts("hold");
    end
  endtask

  initial begin
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(4'($urandom), 3'($urandom), 1'b0, 1'b0);
      chk("idle_rnd_req", rnd_req, 0);
      chk("idle_box", mole_box, 0);
    end
    drive(4'd0, 3'd0, 1'b0, 1'b0);

    start_game();
    round(3'b110, 2, 4'b0100, 4'b0000);
    round(3'($urandom), 0, 4'b0000, 4'b0000);
    round(3'b000, 3, 4'b0010, 4'b0000);
    round(3'b111, 1, 4'b1001, 4'b0000);
    round(3'b001, 1, 4'b0001, 4'b0000);
    round(3'b010, 0, 4'b0000, 4'b0001);
    chk("game_end_flag", exp_over, 1);
    over_hold(5);

    start_game();
    round(3'b101, TO, 4'b0010, 4'b0000);
    for (int i = 0; i < 8; i++) round(3'(i), 1, 4'hF, 4'h0);

    for (int i = 0; i < 40; i++) begin
      if (exp_over) begin
        over_hold(2);
        start_game();
      end
      round(3'($urandom), int'($urandom_range(0, 10)), 4'($urandom_range(1, 15)), 4'h0);
    end
    if (exp_over) start_game();

    while (exp_score < 255) round(3'($urandom), 1, 4'hF, 4'h0);
    round(3'($urandom), 2, 4'hF, 4'h0);
    chk("sat_model", exp_score, 255);

    drive(4'd0, 3'b111, 1'b0, 1'b0);
    drive(4'd0, 3'($urandom), 1'b0, 1'b0);
    chk("mid_show_box", mole_box, 4'b1000);
    drive(4'd0, 3'($urandom), 1'b0, 1'b1);
    drive(4'd0, 3'($urandom), 1'b0, 1'b0);
    exp_score = 0; exp_misses = 0; exp_over = 0;
    chk("midrst_box", mole_box, 0);
    chk("midrst_rnd_req", rnd_req, 0);
    chk_counts("midrst");
    chk("midrst_pulses", {hit_pulse, miss_pulse}, 0);
    chk("midrst_over", game_over, 0);
    for (int i = 0; i < 3; i++) begin
      drive(4'($urandom), 3'($urandom), 1'b0, 1'b0);
      chk("postrst_rnd_req", rnd_req, 0);
    end
    drive(4'd0, 3'd0, 1'b0, 1'b0);
    start_game();
    round(3'b011, 1, 4'b0010, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
